// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg
// Shared definitions for the pulse synchronizer arbiter.
//   arb_state_t       : FSM encoding (IDLE / ISSUE / HOLD)
//   CNT_W_DEFAULT     : default pending-counter width
//   GAP_DEFAULT       : default idle fast cycles after each issued pulse
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    localparam int CNT_W_DEFAULT = 4;
    localparam int GAP_DEFAULT   = 10;

endpackage

// File: rtl/pulse_rr_pick.sv
// pulse_rr_pick
// Combinational round-robin picker. The search starts at rr_ptr and wraps
// modulo N_REQ; the first set request bit wins.
// Ports:
//   req     in  N_REQ  request vector (one bit per requester)
//   rr_ptr  in  ID_W   index where the search starts
//   winner  out ID_W   index of the selected requester (0 when none)
//   any     out 1      at least one request bit is set
module pulse_rr_pick
    import pulse_sync_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    // rr_ptr is always below N_REQ, so one conditional subtract is enough.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return ID_W'(sum);
    endfunction

    logic [ID_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = wrap_idx(rr_ptr, k);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/pulse_sync_arb.sv
// pulse_sync_arb
// Fast-domain arbiter sharing one fast-to-slow pulse synchronizer between
// N_REQ pulse sources. Each source's pulses are counted in a saturating
// pending counter; one pulse at a time is forwarded in round-robin order and
// every pulse is followed by GAP idle cycles so slow-side pulses never merge.
// Ports:
//   clk        in  1      fast clock (synchronizer clk_fast)
//   rst        in  1      synchronous, active-high reset
//   req_pulse  in  N_REQ  single-cycle event per requester
//   ovf_clr    in  N_REQ  clears the matching sticky pend_ovf bits
//   pulse_out  out 1      one-cycle pulse to the synchronizer pulse_fast
//   pulse_id   out ID_W   requester served; stable from ISSUE through HOLD
//   busy       out 1      high in ISSUE and HOLD
//   pend_ovf   out N_REQ  sticky: an event was lost to counter saturation
module pulse_sync_arb
    import pulse_sync_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int GAP   = GAP_DEFAULT,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic [N_REQ-1:0] ovf_clr,
    output logic             pulse_out,
    output logic [ID_W-1:0]  pulse_id,
    output logic             busy,
    output logic [N_REQ-1:0] pend_ovf
);

    localparam int              GAP_W   = $clog2(GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    arb_state_t       state;
    logic [GAP_W-1:0] gap_cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt [N_REQ];

    logic [N_REQ-1:0] nz;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ovf_hit;
    logic [ID_W-1:0]  winner;
    logic             any_req;

    // Saturating pending-counter update; a coincident increment and grant
    // cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
        if (inc && !dec) begin
            return (c == CNT_MAX) ? c : c + 1'b1;
        end
        if (dec && !inc) begin
            return (c == '0) ? c : c - 1'b1;
        end
        return c;
    endfunction

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] w);
        if (int'(w) == N_REQ - 1) begin
            return '0;
        end
        return w + 1'b1;
    endfunction

    // The grant lands at the end of the ISSUE cycle, so a req_pulse in that
    // same cycle leaves the counter unchanged.
    always_comb begin
        grant   = '0;
        nz      = '0;
        ovf_hit = '0;
        if (state == ISSUE) begin
            grant[pulse_id] = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            nz[i]      = (cnt[i] != '0);
            ovf_hit[i] = req_pulse[i] && !grant[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Selection uses registered counter values only; a pulse arriving in the
    // IDLE cycle joins the next round.
    pulse_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (nz),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Pending counters and sticky overflow flags (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
            pend_ovf <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= cnt_next(cnt[i], req_pulse[i], grant[i]);
            end
            pend_ovf <= (pend_ovf & ~ovf_clr) | ovf_hit;
        end
    end

    // Issue FSM with registered outputs. HOLD runs GAP cycles (GAP-1 down
    // to 0), so back-to-back pulses are GAP+2 cycles apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            pulse_id  <= '0;
            busy      <= 1'b0;
            gap_cnt   <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        pulse_out <= 1'b1;
                        busy      <= 1'b1;
                        pulse_id  <= winner;
                        rr_ptr    <= ptr_after(winner);
                    end
                end
                ISSUE: begin
                    state     <= HOLD;
                    pulse_out <= 1'b0;
                    gap_cnt   <= GAP_W'(GAP - 1);
                end
                HOLD: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
